// File: rtl/func_gen_dds.sv
// func_gen_dds: DDS function generator. Phase accumulator feeds a 3-stage sample
// pipeline (S1 phase/settings, S2 raw waveform, S3 gain/offset/saturate).
// New settings are staged in a pending set and swapped in on a phase wrap.
module func_gen_dds #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int TBL_AW = 8,
  parameter int PAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cfg_load,
  input  logic [2:0]        cfg_sig_type,
  input  logic [ACC_W-1:0]  cfg_phase_inc,
  input  logic [DATA_W-1:0] cfg_duty,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [DATA_W-1:0] cfg_amplitude,
  input  logic [DATA_W-1:0] cfg_offset,
  output logic [TBL_AW-1:0] lut_addr,
  input  logic [DATA_W-1:0] lut_din,
  output logic [DATA_W-1:0] wave_out,
  output logic              wave_valid,
  output logic              period_start,
  output logic              cfg_busy,
  output logic              cfg_err
);

  localparam int PAT_AW = $clog2(PAT_W);
  localparam logic [DATA_W-1:0] MAX_V    = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] DUTY_RST = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {
    SIG_SINE     = 3'd0,
    SIG_TRIANGLE = 3'd1,
    SIG_SQUARE   = 3'd2,
    SIG_PWM      = 3'd3,
    SIG_PATTERN  = 3'd4,
    SIG_SAWTOOTH = 3'd5
  } sig_type_e;

  // accumulator and configuration state
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              wrap_pend_q, wrap_pend_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  sig_type_e         act_type_q, act_type_d, pend_type_q, pend_type_d;
  logic [ACC_W-1:0]  act_inc_q, act_inc_d, pend_inc_q, pend_inc_d;
  logic [DATA_W-1:0] act_duty_q, act_duty_d, pend_duty_q, pend_duty_d;
  logic [PAT_W-1:0]  act_pat_q, act_pat_d, pend_pat_q, pend_pat_d;
  logic [DATA_W-1:0] act_amp_q, act_amp_d, pend_amp_q, pend_amp_d;
  logic [DATA_W-1:0] act_off_q, act_off_d, pend_off_q, pend_off_d;
  logic [ACC_W:0]    acc_sum;
  logic              wrap;
  logic              apply;

  // pipeline state
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_p_q, s1_p_d;
  logic [TBL_AW-1:0] lut_addr_q, lut_addr_d;
  sig_type_e         s1_type_q, s1_type_d;
  logic [DATA_W-1:0] s1_duty_q, s1_duty_d;
  logic              s1_pbit_q, s1_pbit_d;
  logic [DATA_W-1:0] s1_amp_q, s1_amp_d;
  logic [DATA_W-1:0] s1_off_q, s1_off_d;
  logic              s1_ps_q, s1_ps_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_raw_q, s2_raw_d;
  logic [DATA_W-1:0] s2_amp_q, s2_amp_d;
  logic [DATA_W-1:0] s2_off_q, s2_off_d;
  logic              s2_ps_q, s2_ps_d;
  logic [DATA_W-1:0] wave_q, wave_d;
  logic              wave_valid_q, wave_valid_d;
  logic              period_start_q, period_start_d;
  logic [DATA_W:0]   amp_p1;
  logic [2*DATA_W:0] prod;
  logic [2*DATA_W:0] wide;

  // Accumulator step, wrap detection and pending->active handover; a load in the
  // same cycle as an apply lands in pending after the old pending was consumed.
  always_comb begin
    acc_sum     = {1'b0, acc_q} + {1'b0, act_inc_q};
    wrap        = enable && acc_sum[ACC_W];
    apply       = busy_q && (wrap || !enable);
    acc_d       = enable ? acc_sum[ACC_W-1:0] : acc_q;
    wrap_pend_d = enable ? wrap : wrap_pend_q;
    act_type_d  = act_type_q;
    act_inc_d   = act_inc_q;
    act_duty_d  = act_duty_q;
    act_pat_d   = act_pat_q;
    act_amp_d   = act_amp_q;
    act_off_d   = act_off_q;
    pend_type_d = pend_type_q;
    pend_inc_d  = pend_inc_q;
    pend_duty_d = pend_duty_q;
    pend_pat_d  = pend_pat_q;
    pend_amp_d  = pend_amp_q;
    pend_off_d  = pend_off_q;
    busy_d      = busy_q && !apply;
    err_d       = 1'b0;
    if (apply) begin
      act_type_d = pend_type_q;
      act_inc_d  = pend_inc_q;
      act_duty_d = pend_duty_q;
      act_pat_d  = pend_pat_q;
      act_amp_d  = pend_amp_q;
      act_off_d  = pend_off_q;
    end
    if (cfg_load) begin
      if (cfg_sig_type <= 3'd5) begin
        pend_type_d = sig_type_e'(cfg_sig_type);
        pend_inc_d  = cfg_phase_inc;
        pend_duty_d = cfg_duty;
        pend_pat_d  = cfg_pattern;
        pend_amp_d  = cfg_amplitude;
        pend_off_d  = cfg_offset;
        busy_d      = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Sample pipeline: settings travel with their sample so a mode change never mixes.
  always_comb begin
    s1_valid_d = enable;
    s1_p_d     = acc_q[ACC_W-1 -: DATA_W];
    lut_addr_d = acc_q[ACC_W-1 -: TBL_AW];
    s1_type_d  = act_type_q;
    s1_duty_d  = act_duty_q;
    s1_pbit_d  = act_pat_q[acc_q[ACC_W-1 -: PAT_AW]];
    s1_amp_d   = act_amp_q;
    s1_off_d   = act_off_q;
    s1_ps_d    = enable && wrap_pend_q;

    s2_raw_d = '0;
    case (s1_type_q)
      SIG_SINE:     s2_raw_d = lut_din;
      SIG_TRIANGLE: s2_raw_d = s1_p_q[DATA_W-1] ? ~{s1_p_q[DATA_W-2:0], 1'b0}
                                                :  {s1_p_q[DATA_W-2:0], 1'b0};
      SIG_SQUARE:   s2_raw_d = s1_p_q[DATA_W-1] ? '0 : MAX_V;
      SIG_PWM:      s2_raw_d = (s1_p_q < s1_duty_q) ? MAX_V : '0;
      SIG_PATTERN:  s2_raw_d = s1_pbit_q ? MAX_V : '0;
      SIG_SAWTOOTH: s2_raw_d = s1_p_q;
      default:      s2_raw_d = '0;
    endcase
    s2_valid_d = s1_valid_q;
    s2_amp_d   = s1_amp_q;
    s2_off_d   = s1_off_q;
    s2_ps_d    = s1_ps_q;

    amp_p1 = {1'b0, s2_amp_q} + {{DATA_W{1'b0}}, 1'b1};
    prod   = {{(DATA_W+1){1'b0}}, s2_raw_q} * {{DATA_W{1'b0}}, amp_p1};
    wide   = (prod >> DATA_W) + {{(DATA_W+1){1'b0}}, s2_off_q};
    wave_d = wave_q;
    if (s2_valid_q) begin
      wave_d = (wide > {{(DATA_W+1){1'b0}}, MAX_V}) ? MAX_V : wide[DATA_W-1:0];
    end
    wave_valid_d   = s2_valid_q;
    period_start_d = s2_valid_q && s2_ps_q;
  end

  // Control and configuration registers; reset restores the power-on settings.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      wrap_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      act_type_q  <= SIG_SINE;
      act_inc_q   <= '0;
      act_duty_q  <= DUTY_RST;
      act_pat_q   <= '0;
      act_amp_q   <= MAX_V;
      act_off_q   <= '0;
      pend_type_q <= SIG_SINE;
      pend_inc_q  <= '0;
      pend_duty_q <= DUTY_RST;
      pend_pat_q  <= '0;
      pend_amp_q  <= MAX_V;
      pend_off_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      wrap_pend_q <= wrap_pend_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      act_type_q  <= act_type_d;
      act_inc_q   <= act_inc_d;
      act_duty_q  <= act_duty_d;
      act_pat_q   <= act_pat_d;
      act_amp_q   <= act_amp_d;
      act_off_q   <= act_off_d;
      pend_type_q <= pend_type_d;
      pend_inc_q  <= pend_inc_d;
      pend_duty_q <= pend_duty_d;
      pend_pat_q  <= pend_pat_d;
      pend_amp_q  <= pend_amp_d;
      pend_off_q  <= pend_off_d;
    end
  end

  // Pipeline registers; everything clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_p_q         <= '0;
      lut_addr_q     <= '0;
      s1_type_q      <= SIG_SINE;
      s1_duty_q      <= '0;
      s1_pbit_q      <= 1'b0;
      s1_amp_q       <= '0;
      s1_off_q       <= '0;
      s1_ps_q        <= 1'b0;
      s2_valid_q     <= 1'b0;
      s2_raw_q       <= '0;
      s2_amp_q       <= '0;
      s2_off_q       <= '0;
      s2_ps_q        <= 1'b0;
      wave_q         <= '0;
      wave_valid_q   <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_p_q         <= s1_p_d;
      lut_addr_q     <= lut_addr_d;
      s1_type_q      <= s1_type_d;
      s1_duty_q      <= s1_duty_d;
      s1_pbit_q      <= s1_pbit_d;
      s1_amp_q       <= s1_amp_d;
      s1_off_q       <= s1_off_d;
      s1_ps_q        <= s1_ps_d;
      s2_valid_q     <= s2_valid_d;
      s2_raw_q       <= s2_raw_d;
      s2_amp_q       <= s2_amp_d;
      s2_off_q       <= s2_off_d;
      s2_ps_q        <= s2_ps_d;
      wave_q         <= wave_d;
      wave_valid_q   <= wave_valid_d;
      period_start_q <= period_start_d;
    end
  end

  assign lut_addr     = lut_addr_q;
  assign wave_out     = wave_q;
  assign wave_valid   = wave_valid_q;
  assign period_start = period_start_q;
  assign cfg_busy     = busy_q;
  assign cfg_err      = err_q;

endmodule
